fir_tdm: RTL

Time-multiplexed, multi-channel FIR filter: one shared multiply-accumulate unit serially processes N_TAPS taps per input sample, with a per-channel circular sample buffer and a runtime-writable coefficient bank. It is the parametrised successor to the fixed-coefficient, fully parallel audio FIR. It sits in the same sample path between the audio source and the output stage, and trades throughput (N_TAPS+3 cycles per sample) for a single multiplier. It uses valid/ready handshakes on input and a valid pulse on output.

---
 rtl/fir_tdm.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fir_tdm.sv
// Time-multiplexed multi-channel FIR: one shared MAC, N_TAPS+3 cycles per sample.
// Define FIR_SAT_EN to saturate the output; otherwise the shifted result wraps to DATA_W bits.
module fir_tdm #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned N_TAPS    = 61,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned OUT_SHIFT = COEF_W - 1,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned TAP_W    = $clog2(N_TAPS),
    localparam int unsigned ACC_W    = DATA_W + COEF_W + TAP_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [TAP_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);
    localparam logic [TAP_W:0]   TAP_LIM  = (TAP_W + 1)'(N_TAPS);
    localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(N_CH);

    typedef enum logic [1:0] {StIdle, StMac, StFlush, StOut} state_e;

    state_e                    state_q;
    logic                      ready_q;
    logic [CH_W-1:0]           ch_q;
    logic [TAP_W-1:0]          k_q;
    logic [TAP_W-1:0]          rd_q;
    logic [TAP_W-1:0]          wr_ptr_q [N_CH];
    logic signed [DATA_W-1:0]  buf_q    [N_CH][N_TAPS];
    logic signed [COEF_W-1:0]  coef_q   [N_TAPS];
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      out_valid_q;
    logic [CH_W-1:0]           out_ch_q;
    logic [DATA_W-1:0]         out_data_q;

    logic [TAP_W-1:0]          wr_next;
    logic                      ch_ok;
    logic                      coef_ok;
    logic signed [COEF_W-1:0]  coef_cur;
    logic signed [DATA_W-1:0]  samp_cur;
    logic signed [PROD_W-1:0]  mul;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [DATA_W-1:0]         result;
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0]   shifted;
`endif

    always_comb begin
        wr_next  = (wr_ptr_q[in_ch] == LAST_TAP) ? '0 : wr_ptr_q[in_ch] + TAP_W'(1);
        ch_ok    = {1'b0, in_ch} < CH_LIM;
        coef_ok  = {1'b0, coef_addr} < TAP_LIM;
        coef_cur = coef_q[k_q];
        samp_cur = buf_q[ch_q][rd_q];
        mul      = $signed({{DATA_W{coef_cur[COEF_W-1]}}, coef_cur})
                 * $signed({{COEF_W{samp_cur[DATA_W-1]}}, samp_cur});
        acc_sum  = acc_q + $signed({{TAP_W{prod_q[PROD_W-1]}}, prod_q});
`ifdef FIR_SAT_EN
        shifted  = acc_sum >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
`else
        result   = DATA_W'(acc_sum >>> OUT_SHIFT);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            ch_q        <= '0;
            k_q         <= '0;
            rd_q        <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                wr_ptr_q[c] <= '0;
                for (int t = 0; t < int'(N_TAPS); t++) begin
                    buf_q[c][t] <= '0;
                end
            end
            for (int t = 0; t < int'(N_TAPS); t++) begin
                coef_q[t] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            // ready_q is high only in StIdle, so this also gates writes while busy
            if (coef_we && ready_q && coef_ok) begin
                coef_q[coef_addr] <= coef_data;
            end
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    // Out-of-range channels complete the handshake but are dropped
                    if (in_valid && ready_q && ch_ok) begin
                        wr_ptr_q[in_ch]       <= wr_next;
                        buf_q[in_ch][wr_next] <= in_data;
                        ch_q    <= in_ch;
                        rd_q    <= wr_next;
                        k_q     <= '0;
                        acc_q   <= '0;
                        prod_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    prod_q <= mul;
                    acc_q  <= acc_sum;
                    rd_q   <= (rd_q == '0) ? LAST_TAP : rd_q - TAP_W'(1);
                    k_q    <= k_q + TAP_W'(1);
                    if (k_q == LAST_TAP) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    acc_q       <= acc_sum;
                    out_data_q  <= result;
                    out_ch_q    <= ch_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule
